// File: rtl/sync_rx_checker.sv
// rtl/sync_rx_checker.sv - destination-side incrementing-sequence checker for synchronizer tests
//
// Purpose:
//   Runs in the receiving clock domain. Consumes strobe-qualified words from a
//   synchronizer under test and checks them against an incrementing reference
//   sequence seeded by the first word of each run. Reports the received-word
//   count, the error count, the first bad word and a pass/fail verdict.
//
// Optional feature:
//   `SYNC_RX_TIMEOUT_EN` enables an idle watchdog that ends a run with
//   timeout=1 after TIMEOUT ena-qualified cycles without a strobe. When it is
//   undefined there is no watchdog, o_timeout stays 0 and a run waits
//   indefinitely.
//
// Parameters:
//   N        data width
//   CNT_W    width of the word and error counters
//   LEN      words per run (1 .. 2^CNT_W-1)
//   TIMEOUT  watchdog idle-cycle limit (>= 1)
//
// Ports:
//   i_clk          receiving-domain clock, rising edge
//   i_rst          synchronous active-high reset
//   i_ena          block enable; gates start, valid and the watchdog
//   i_start        single-cycle request to begin or restart a run
//   i_valid        one-cycle strobe marking a delivered word
//   i_data         delivered word, sampled on i_valid && i_ena
//   o_busy         run in progress (ALIGN or CHECK)
//   o_done         run finished (DONE)
//   o_pass         in DONE: no mismatches and no timeout
//   o_err_flag     sticky, set on the first mismatch of a run
//   o_timeout      sticky, watchdog expired during the run
//   o_word_count   words accepted in this run
//   o_err_count    mismatches, saturating
//   o_first_err    received value of the first mismatched word, else 0

module sync_rx_checker #(
  parameter int N       = 8,
  parameter int CNT_W   = 8,
  parameter int LEN     = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [N-1:0]     i_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_err_flag,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_word_count,
  output logic [CNT_W-1:0] o_err_count,
  output logic [N-1:0]     o_first_err
);

  if (LEN < 1 || LEN > (2 ** CNT_W) - 1 || TIMEOUT < 1) begin : g_param_chk
    $error("sync_rx_checker: LEN or TIMEOUT out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [N-1:0]     r_expected;
  logic [CNT_W-1:0] r_word_count;
  logic [CNT_W-1:0] r_err_count;
  logic             r_err_flag;
  logic             r_timeout;
  logic [N-1:0]     r_first_err;

  logic             w_start;
  logic             w_valid;
  logic             w_run;
  logic             w_last_word;
  logic             w_wd_expire;

  // start outranks valid; both are ignored while the block is disabled
  assign w_start     = i_start & i_ena;
  assign w_valid     = i_valid & i_ena & ~i_start;
  assign w_run       = (r_state == S_ALIGN) || (r_state == S_CHECK);
  // the CHECK word that brings word_count up to LEN closes the run
  assign w_last_word = (r_word_count == CNT_W'(LEN - 1));

`ifdef SYNC_RX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wd;

  // r_wd holds the number of idle enabled cycles seen so far; the run ends on
  // the enabled idle cycle after it reaches TIMEOUT
  assign w_wd_expire = w_run && i_ena && !i_start && !i_valid &&
                       (r_wd == WD_W'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wd <= '0;
    end else if (w_start || (w_run && w_valid) || w_wd_expire) begin
      r_wd <= '0;
    end else if (w_run && i_ena) begin
      r_wd <= r_wd + 1'b1;
    end
  end
`else
  assign w_wd_expire = 1'b0;
`endif

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_ALIGN;
      end
      S_ALIGN: begin
        if (w_start)          w_state_nxt = S_ALIGN;
        else if (w_valid)     w_state_nxt = (LEN == 1) ? S_DONE : S_CHECK;
        else if (w_wd_expire) w_state_nxt = S_DONE;
      end
      S_CHECK: begin
        if (w_start)                     w_state_nxt = S_ALIGN;
        else if (w_valid && w_last_word) w_state_nxt = S_DONE;
        else if (w_wd_expire)            w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_start) w_state_nxt = S_ALIGN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // run datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_expected   <= '0;
      r_word_count <= '0;
      r_err_count  <= '0;
      r_err_flag   <= 1'b0;
      r_timeout    <= 1'b0;
      r_first_err  <= '0;
    end else if (w_start) begin
      // every entry into ALIGN starts from a clean slate
      r_word_count <= '0;
      r_err_count  <= '0;
      r_err_flag   <= 1'b0;
      r_timeout    <= 1'b0;
      r_first_err  <= '0;
    end else begin
      case (r_state)
        S_ALIGN: begin
          if (w_valid) begin
            r_expected   <= i_data + 1'b1;
            r_word_count <= CNT_W'(1);
          end else if (w_wd_expire) begin
            r_timeout <= 1'b1;
          end
        end
        S_CHECK: begin
          if (w_valid) begin
            r_word_count <= r_word_count + 1'b1;
            // no resync on mismatch: a lost or extra strobe keeps failing
            r_expected   <= r_expected + 1'b1;
            if (i_data != r_expected) begin
              r_err_flag <= 1'b1;
              if (r_err_count != {CNT_W{1'b1}}) begin
                r_err_count <= r_err_count + 1'b1;
              end
              if (!r_err_flag) begin
                r_first_err <= i_data;
              end
            end
          end else if (w_wd_expire) begin
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs, all derived from registered state only
  always_comb begin
    o_busy       = w_run;
    o_done       = (r_state == S_DONE);
    o_pass       = (r_state == S_DONE) && (r_err_count == '0) && !r_timeout;
    o_err_flag   = r_err_flag;
    o_timeout    = r_timeout;
    o_word_count = r_word_count;
    o_err_count  = r_err_count;
    o_first_err  = r_first_err;
  end

endmodule

// File: tb/tb_sync_rx_checker.sv
// tb/tb_sync_rx_checker.sv - scoreboard bench for sync_rx_checker
module tb_sync_rx_checker;

  localparam int LEN     = 16;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       start;
  logic       valid;
  logic [7:0] data;
  logic       busy, done, pass, err_flag, timeout;
  logic [7:0] word_count, err_count, first_err;

  sync_rx_checker #(.N(8), .CNT_W(8), .LEN(LEN), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_start(start), .i_valid(valid),
    .i_data(data), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_err_flag(err_flag), .o_timeout(timeout), .o_word_count(word_count),
    .o_err_count(err_count), .o_first_err(first_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] wc;
    logic [7:0] ec;
    logic [7:0] fe;
    logic       ef;
    logic       ps;
    logic       to;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] words[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: first word is the base, the rest must increment from it
  function automatic exp_t model(input bit to);
    exp_t       e;
    logic [7:0] nxt;
    e.wc = 8'(words.size());
    e.ec = 0; e.fe = 0; e.ef = 0;
    nxt = words[0] + 8'd1;
    for (int i = 1; i < words.size(); i++) begin
      if (words[i] != nxt) begin
        if (!e.ef) e.fe = words[i];
        e.ef = 1'b1;
        e.ec = e.ec + 8'd1;
      end
      nxt = nxt + 8'd1;
    end
    e.to = to;
    e.ps = (e.ec == 0) && !to;
    return e;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d);
    valid = 1'b1;
    data  = d;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic send_words(input int from, input int to);
    for (int i = from; i < to; i++) send_word(words[i]);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_done"},  done,       1);
    chk({tag, "_wc"},    word_count, e.wc);
    chk({tag, "_ec"},    err_count,  e.ec);
    chk({tag, "_ef"},    err_flag,   e.ef);
    chk({tag, "_fe"},    first_err,  e.fe);
    chk({tag, "_pass"},  pass,       e.ps);
    chk({tag, "_to"},    timeout,    e.to);
    chk({tag, "_busy"},  busy,       0);
  endtask

  // done must already be up at the negedge after the final strobe
  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 0);
    compare_result(tag);
  endtask

  task automatic full_run(input string tag);
    sb.push_back(model(1'b0));
    do_start();
    chk({tag, "_busy_start"}, busy, 1);
    send_words(0, LEN - 1);
    chk({tag, "_early_done"}, done, 0);
    send_words(LEN - 1, LEN);
    wait_done(tag);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; start = 1'b0; valid = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_wc",   word_count, 0);
    chk("rst_ec",   err_count, 0);
    chk("rst_fe",   first_err, 0);

    // valid in IDLE is ignored
    send_word(8'h33);
    chk("idle_valid_wc", word_count, 0);

    // clean run 10..1F
    words.delete();
    for (int i = 0; i < LEN; i++) words.push_back(8'(8'h10 + i));
    full_run("clean");
    chk("clean_pass_const", pass, 1);

    // word 5 corrupted
    words[5] = 8'hAA;
    full_run("bad5");
    chk("bad5_fe_const", first_err, 8'hAA);

    // wrap through FF -> 00
    words.delete();
    for (int i = 0; i < LEN; i++) words.push_back(8'(8'hFE + i));
    full_run("wrap");

    // dropped strobe: 0..7 then 9..16
    words.delete();
    for (int i = 0; i <= 16; i++) if (i != 8) words.push_back(8'(i));
    full_run("drop");
    chk("drop_ec_const", err_count, 8);
    chk("drop_fe_const", first_err, 8'h09);

    // restart in CHECK coincident with valid
    words.delete();
    for (int i = 0; i < 6; i++) words.push_back(8'(8'h50 + i));
    do_start();
    send_words(0, 6);
    start = 1'b1; valid = 1'b1; data = 8'h99;
    @(negedge clk);
    start = 1'b0; valid = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_wc",   word_count, 0);
    words.delete();
    for (int i = 0; i < LEN; i++) words.push_back(8'(8'h30 + i));
    sb.push_back(model(1'b0));
    send_words(0, LEN);
    wait_done("restart");

    // ena low pauses: strobes and start ignored
    words.delete();
    for (int i = 0; i < LEN; i++) words.push_back(8'(8'h40 + i));
    sb.push_back(model(1'b0));
    do_start();
    send_words(0, 4);
    ena = 1'b0; start = 1'b1; valid = 1'b1; data = 8'hEE;
    repeat (3) @(negedge clk);
    ena = 1'b1; start = 1'b0; valid = 1'b0;
    chk("pause_wc",   word_count, 4);
    chk("pause_busy", busy, 1);
    send_words(4, LEN);
    wait_done("pause");

    // silence after 3 words
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back(8'(8'h70 + i));
`ifdef SYNC_RX_TIMEOUT_EN
    sb.push_back(model(1'b1));
    do_start();
    send_words(0, 3);
    begin
      int n = 0;
      while (done !== 1'b1 && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("wd_latency", n, TIMEOUT + 1);
    end
    compare_result("wd");
`else
    do_start();
    send_words(0, 3);
    repeat (300) @(negedge clk);
    chk("nowd_busy", busy, 1);
    chk("nowd_done", done, 0);
    chk("nowd_to",   timeout, 0);
    chk("nowd_wc",   word_count, 3);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_rx_checker.md
# sync_rx_checker

Destination-side checker for the synchronizer test structure. Runs in the receiving clock domain, consumes strobe-qualified words delivered by a synchronizer under test, and checks them against an incrementing reference sequence. Reports received-word count, error count, first bad word and a pass/fail verdict. Its output is muxed onto the dedicated outputs alongside the raw synchronizer outputs.

## Interface

Parameters:
- `N`, default 8: data width.
- `CNT_W`, default 8: width of the word and error counters.
- `LEN`, default 16: words per check run, from 1 to 2^CNT_W−1.
- `TIMEOUT`, default 255: idle-cycle limit (≥1) for the watchdog.

Ports:
- `clk`  in  1  receiving-domain clock; all logic on its rising edge.
- `rst`  in  1  reset; **synchronous, active-high**.
- `ena`  in  1  block enable; when low, `start`/`valid` are ignored and the watchdog timer is frozen.
- `start`  in  1  single-cycle request to begin or restart a run.
- `valid`  in  1  one-cycle strobe marking a delivered word (synchronizer `stb_out`/`pulse_out`).
- `data`  in  N  delivered word; sampled only when `valid && ena`.
- `busy`  out  1  high in ALIGN and CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE iff `err_count==0` and no timeout occurred.
- `err_flag`  out  1  sticky; set on the first mismatch of a run.
- `timeout`  out  1  sticky; watchdog expired during the run.
- `word_count`  out  CNT_W  words accepted in this run.
- `err_count`  out  CNT_W  mismatches; saturates at 2^CNT_W−1.
- `first_err`  out  N  received value of the first mismatched word; 0 if there was none.

## Operation

States: IDLE, ALIGN, CHECK, DONE. Encoding is free.

- **IDLE**: `busy=0`, `done=0`. On `start&&ena`, go to ALIGN.
- **Entering ALIGN** (from any state): clear `word_count`, `err_count`, `err_flag`, `timeout`, `first_err`, `pass` and the watchdog timer.
- **ALIGN**: the first `valid&&ena` word becomes the base.
  - `expected <= data+1` (mod 2^N).
  - `word_count <= 1`.
  - Go to CHECK, or to DONE if `LEN==1`.
  - The base word is never counted as an error.
- **CHECK**: on each `valid&&ena`:
  - `word_count++`.
  - If `data != expected`: `err_count++` (saturating), set `err_flag`, and if `err_flag` was 0, capture `first_err <= data`.
  - `expected <= expected+1` unconditionally. The sequence is not resynchronised, so a dropped or duplicated strobe makes every later word mismatch. This is intentional: it detects lost pulses.
  - On the word that makes `word_count==LEN`, go to DONE.
- **DONE**: hold all counters. `pass = (err_count==0) && !timeout`. Stay until `start&&ena`, then go to ALIGN.
- **Priority**: `rst` > `start` > `valid`. In ALIGN or CHECK, `start` restarts the run and the coincident `valid` is dropped. In IDLE or DONE, `valid` is ignored.
- **Wrap**: `expected` wraps from 2^N−1 to 0. A base of 8'hFF expects 8'h00 next.

## Timing

- Reset (rst sampled high): state IDLE, all outputs 0, `expected=0`.
- Every output is registered. Effects of `start`, `valid` or timeout are visible the cycle after the sampling edge.
- Latency from the final `valid` to `done=1`/`pass` valid: 1 cycle.
- Back-to-back `valid` on consecutive cycles is fully supported, at one word per cycle.
- Holding `valid` high for k cycles counts as k words. Upstream must deliver single-cycle strobes.
- An `ena` low period pauses the run with no state change. The run resumes on the next `ena`-qualified strobe.

## Configuration

- Macro `SYNC_RX_TIMEOUT_EN`.
- **Defined**: a watchdog counts `ena` cycles in ALIGN/CHECK without a `valid`.
  - The count resets on each accepted `valid`.
  - When it reaches `TIMEOUT`: set `timeout`, go to DONE (`pass=0`). `done` rises TIMEOUT+1 cycles after the last accepted edge.
- **Undefined**: no watchdog logic. `timeout` is tied 0 and ALIGN/CHECK wait indefinitely.

## Test plan

1. Reset, then `start`, then LEN=16 strobes with data 8'h10..8'h1F → `done=1`, `pass=1`, `word_count=16`, `err_count=0`, `first_err=0`.
2. Same as 1, but word 5 = 8'hAA → `err_count=1`, `err_flag=1`, `first_err=8'hAA`, `pass=0`.
3. Base 8'hFE, 16 incrementing words wrapping through 8'hFF→8'h00 → `pass=1`.
4. Drop one strobe mid-run (words 0..7, then 9..16) → `err_count=8`, `first_err=8'h09`, `pass=0`.
5. `start` asserted in CHECK at the same cycle as `valid` after 6 words → counters cleared, `busy=1`, next word becomes the base, and a full clean run gives `pass=1`.
6. With `SYNC_RX_TIMEOUT_EN` and TIMEOUT=255: `start`, 3 words, then silence → `timeout=1`, `done=1`, `pass=0`, `word_count=3`. Without the macro, same stimulus → `busy` stays 1 and `timeout=0`.
